// File: rtl/acc_exec_ctrl_if.sv
// Instruction, register-load, ALU and status bundle for acc_exec_ctrl.
// slave = controller side, master = instruction source / ALU / observer side.
interface acc_exec_ctrl_if #(
    parameter int SIZE   = 8,
    parameter int REG_AW = 4
);
    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [REG_AW-1:0] instr_reg;
    logic              instr_use_carry;

    logic              ld_we;
    logic [REG_AW-1:0] ld_addr;
    logic [SIZE-1:0]   ld_data;

    logic              alu_ce;
    logic [2:0]        alu_op;
    logic [SIZE-1:0]   alu_left;
    logic [SIZE-1:0]   alu_right;
    logic              alu_carry_in;
    logic              alu_carry_out;
    logic [SIZE-1:0]   alu_result;

    logic [SIZE-1:0]   acc;
    logic              carry_flag;
    logic              zero_flag;
    logic              result_valid;

    modport slave (
        input  instr_valid, instr_op, instr_reg, instr_use_carry,
        input  ld_we, ld_addr, ld_data,
        input  alu_carry_out, alu_result,
        output instr_ready, alu_ce, alu_op, alu_left, alu_right, alu_carry_in,
        output acc, carry_flag, zero_flag, result_valid
    );

    modport master (
        output instr_valid, instr_op, instr_reg, instr_use_carry,
        output ld_we, ld_addr, ld_data,
        output alu_carry_out, alu_result,
        input  instr_ready, alu_ce, alu_op, alu_left, alu_right, alu_carry_in,
        input  acc, carry_flag, zero_flag, result_valid
    );
endinterface

// File: rtl/acc_exec_ctrl.sv
// Accumulator execution controller feeding the ALU; owns acc, C/Z flags and register file.
// Latency: accept->commit 2 cycles (IDLE/EXEC/WB), 1 cycle with ACC_EXEC_FAST_EN (WB removed).
// Backpressure: instr_ready only in IDLE, so one instruction in flight at a time.
module acc_exec_ctrl #(
    parameter int SIZE   = 8,
    parameter int REG_AW = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    acc_exec_ctrl_if.slave bus
);
    // Only the opcodes with special commit behaviour are named; the rest share the logic path.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_ST  = 3'd7;

`ifdef ACC_EXEC_FAST_EN
    typedef enum logic [1:0] {IDLE, EXEC} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
`endif

    state_t            state_q, state_d;
    logic              ready, ce, rvld, commit;
    logic [2:0]        op_q;
    logic [REG_AW-1:0] idx_q;
    logic              cin_q;
    logic [SIZE-1:0]   acc_q;
    logic              c_q, z_q;
    logic [SIZE-1:0]   rf [0:(1<<REG_AW)-1];
    logic [SIZE-1:0]   res;
    logic              cout;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        ce      = 1'b0;
        rvld    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (bus.instr_valid) state_d = EXEC;
            end
            EXEC: begin
                ce = 1'b1;
`ifdef ACC_EXEC_FAST_EN
                rvld    = 1'b1;
                commit  = 1'b1;
                state_d = IDLE;
`else
                state_d = WB;
`endif
            end
`ifndef ACC_EXEC_FAST_EN
            WB: begin
                rvld    = 1'b1;
                commit  = 1'b1;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

`ifdef ACC_EXEC_FAST_EN
    assign res  = bus.alu_result;
    assign cout = bus.alu_carry_out;
`else
    logic [SIZE-1:0] res_q;
    logic            cout_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_q  <= '0;
            cout_q <= 1'b0;
        end else if (state_q == EXEC) begin
            res_q  <= bus.alu_result;
            cout_q <= bus.alu_carry_out;
        end
    end

    assign res  = res_q;
    assign cout = cout_q;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q  <= '0;
            idx_q <= '0;
            cin_q <= 1'b0;
            acc_q <= '0;
            c_q   <= 1'b0;
            z_q   <= 1'b1;
            for (int i = 0; i < (1 << REG_AW); i++) rf[i] <= '0;
        end else begin
            // Carry-in is frozen at acceptance so it holds its value after the commit updates C.
            if (ready && bus.instr_valid) begin
                op_q  <= bus.instr_op;
                idx_q <= bus.instr_reg;
                cin_q <= bus.instr_use_carry & c_q;
            end
            if (bus.ld_we) rf[bus.ld_addr] <= bus.ld_data;
            // A store commit is written after the external load so it wins on an address clash.
            if (commit) begin
                if (op_q == OP_ST) begin
                    rf[idx_q] <= res;
                end else begin
                    acc_q <= res;
                    z_q   <= (res == '0);
                    if (op_q == OP_ADD || op_q == OP_SUB) c_q <= cout;
                end
            end
        end
    end

    assign bus.instr_ready  = ready;
    assign bus.alu_ce       = ce;
    assign bus.result_valid = rvld;
    assign bus.alu_op       = op_q;
    assign bus.alu_left     = acc_q;
    assign bus.alu_right    = rf[idx_q];
    assign bus.alu_carry_in = cin_q;
    assign bus.acc          = acc_q;
    assign bus.carry_flag   = c_q;
    assign bus.zero_flag    = z_q;
endmodule

// File: tb/tb_acc_exec_ctrl.sv
// Directed plus randomized bench for acc_exec_ctrl with a behavioural ALU and reference model.
module tb_acc_exec_ctrl;
`ifdef ACC_EXEC_FAST_EN
    localparam int PER  = 2;
    localparam bit FAST = 1'b1;
`else
    localparam int PER  = 3;
    localparam bit FAST = 1'b0;
`endif
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                           XOR_ = 3'd4, NOT_ = 3'd5, LD = 3'd6, ST = 3'd7;

    logic CLK, RST_N;
    acc_exec_ctrl_if #(.SIZE(8), .REG_AW(4)) bus ();

    acc_exec_ctrl #(.SIZE(8), .REG_AW(4)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] m_rf [16];
    logic [7:0] m_acc;
    logic       m_c, m_z;

    function automatic logic [8:0] ref_alu(input logic [2:0] op, input logic [7:0] l,
                                           input logic [7:0] r, input logic cin);
        int s;
        case (op)
            ADD:  begin s = int'(l) + int'(r) + int'(cin); return {s > 255, 8'(s)}; end
            SUB:  begin s = int'(l) - int'(r) - int'(cin); return {s < 0, 8'(s)}; end
            AND_: return {1'b0, l & r};
            OR_:  return {1'b0, l | r};
            XOR_: return {1'b0, l ^ r};
            NOT_: return {1'b0, ~l};
            LD:   return {1'b0, r};
            default: return {1'b0, l};
        endcase
    endfunction

    // ALU stand-in attached to the controller.
    always_comb begin
        {bus.alu_carry_out, bus.alu_result} = ref_alu(bus.alu_op, bus.alu_left,
                                                      bus.alu_right, bus.alu_carry_in);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_acc = 8'h00; m_c = 1'b0; m_z = 1'b1;
        for (int i = 0; i < 16; i++) m_rf[i] = 8'h00;
    endtask

    task automatic do_ld(input logic [3:0] a, input logic [7:0] d);
        bus.ld_we = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        tick();
        bus.ld_we = 1'b0;
        m_rf[a] = d;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_acc"}, bus.acc, m_acc);
        check({tag, "_c"}, bus.carry_flag, m_c);
        check({tag, "_z"}, bus.zero_flag, m_z);
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] idx, input logic uc,
                         input logic ld_en, input logic [3:0] ld_a, input logic [7:0] ld_d);
        logic [8:0] r;
        logic       cin;
        logic [7:0] rv;
        int w;
        w = 0;
        while (!bus.instr_ready && w < 20) begin tick(); w++; end
        check("ready_wait", bus.instr_ready, 1'b1);
        cin = uc & m_c;
        rv  = m_rf[idx];
        bus.instr_valid = 1'b1; bus.instr_op = op; bus.instr_reg = idx; bus.instr_use_carry = uc;
        tick();
        bus.instr_valid = 1'b0;
        bus.instr_op = $urandom; bus.instr_reg = $urandom; bus.instr_use_carry = $urandom;
        check("exec_ce", bus.alu_ce, 1'b1);
        check("exec_op", bus.alu_op, op);
        check("exec_right", bus.alu_right, rv);
        check("exec_left", bus.alu_left, m_acc);
        check("exec_cin", bus.alu_carry_in, cin);
        check("exec_ready", bus.instr_ready, 1'b0);
        check("exec_rvld", bus.result_valid, FAST);
        r = ref_alu(op, m_acc, rv, cin);
        if (!FAST) begin
            tick();
            check("wb_rvld", bus.result_valid, 1'b1);
            check("wb_ce", bus.alu_ce, 1'b0);
        end
        if (ld_en) begin bus.ld_we = 1'b1; bus.ld_addr = ld_a; bus.ld_data = ld_d; end
        tick();
        bus.ld_we = 1'b0;
        if (ld_en) m_rf[ld_a] = ld_d;
        if (op == ST) m_rf[idx] = r[7:0];
        else begin
            m_acc = r[7:0];
            m_z   = (r[7:0] == 8'h00);
            if (op == ADD || op == SUB) m_c = r[8];
        end
        check_state("commit");
        check("post_ready", bus.instr_ready, 1'b1);
        check("post_rvld", bus.result_valid, 1'b0);
        check("post_op_hold", bus.alu_op, op);
        check("post_cin_hold", bus.alu_carry_in, cin);
    endtask

    initial begin
        logic [2:0] b_op [3];
        logic [3:0] b_rg [3];
        int acc_cyc [3];
        int k, pulses;
        logic rdy;
        logic [8:0] r;

        bus.instr_valid = 1'b0; bus.instr_op = '0; bus.instr_reg = '0; bus.instr_use_carry = 1'b0;
        bus.ld_we = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        RST_N = 1'b0;
        model_reset();
        #12;
        check_state("reset");
        check("reset_ready", bus.instr_ready, 1'b1);
        check("reset_ce", bus.alu_ce, 1'b0);
        check("reset_rvld", bus.result_valid, 1'b0);
        check("reset_op", bus.alu_op, 3'd0);
        check("reset_cin", bus.alu_carry_in, 1'b0);
        check("reset_right", bus.alu_right, 8'h00);
        RST_N = 1'b1;
        tick();

        // Directed cases
        do_ld(4'd3, 8'h05);
        issue(LD, 4'd3, 1'b0, 1'b0, 4'd0, 8'h00);
        check("ld_acc_const", bus.acc, 8'h05);

        do_ld(4'd1, 8'h01);
        do_ld(4'd4, 8'hFF);
        issue(LD, 4'd4, 1'b0, 1'b0, 4'd0, 8'h00);
        issue(ADD, 4'd1, 1'b0, 1'b0, 4'd0, 8'h00);
        check("add_wrap_acc", bus.acc, 8'h00);
        check("add_wrap_c", bus.carry_flag, 1'b1);
        check("add_wrap_z", bus.zero_flag, 1'b1);

        do_ld(4'd5, 8'h10);
        do_ld(4'd2, 8'h20);
        issue(LD, 4'd5, 1'b0, 1'b0, 4'd0, 8'h00);
        issue(ADD, 4'd2, 1'b1, 1'b0, 4'd0, 8'h00);
        check("addc_acc", bus.acc, 8'h31);
        check("addc_c", bus.carry_flag, 1'b0);

        do_ld(4'd6, 8'h5A);
        issue(LD, 4'd6, 1'b0, 1'b0, 4'd0, 8'h00);
        issue(ST, 4'd7, 1'b0, 1'b1, 4'd7, 8'h11);
        check("st_acc_kept", bus.acc, 8'h5A);
        issue(LD, 4'd7, 1'b0, 1'b0, 4'd0, 8'h00);
        check("st_wins_r7", bus.acc, 8'h5A);

        // Back-to-back with instr_valid held high
        for (int i = 0; i < 3; i++) begin
            b_rg[i] = 4'(8 + i);
            do_ld(b_rg[i], 8'($urandom));
        end
        b_op[0] = LD; b_op[1] = ADD; b_op[2] = XOR_;
        for (int i = 0; i < 3; i++) begin
            r = ref_alu(b_op[i], m_acc, m_rf[b_rg[i]], 1'b0);
            m_acc = r[7:0];
            m_z   = (r[7:0] == 8'h00);
            if (b_op[i] == ADD) m_c = r[8];
        end
        k = 0; pulses = 0;
        for (int i = 0; i < 3; i++) acc_cyc[i] = -100;
        bus.instr_valid = 1'b1; bus.instr_op = b_op[0]; bus.instr_reg = b_rg[0]; bus.instr_use_carry = 1'b0;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            rdy = bus.instr_ready;
            tick();
            if (bus.result_valid) pulses++;
            if (rdy && bus.instr_valid) begin
                acc_cyc[k] = cyc;
                k++;
                if (k < 3) begin bus.instr_op = b_op[k]; bus.instr_reg = b_rg[k]; end
                else bus.instr_valid = 1'b0;
            end
        end
        bus.instr_valid = 1'b0;
        check("b2b_accepted", k, 3);
        check("b2b_gap1", acc_cyc[1] - acc_cyc[0], PER);
        check("b2b_gap2", acc_cyc[2] - acc_cyc[1], PER);
        check("b2b_pulses", pulses, 3);
        check_state("b2b");

        // Reset asserted during EXEC aborts the instruction
        do_ld(4'd9, 8'h77);
        bus.instr_valid = 1'b1; bus.instr_op = ADD; bus.instr_reg = 4'd9; bus.instr_use_carry = 1'b0;
        tick();
        bus.instr_valid = 1'b0;
        check("rst_pre_ce", bus.alu_ce, 1'b1);
        #2 RST_N = 1'b0;
        #1;
        model_reset();
        check_state("rst_mid");
        check("rst_mid_ready", bus.instr_ready, 1'b1);
        check("rst_mid_ce", bus.alu_ce, 1'b0);
        check("rst_mid_rvld", bus.result_valid, 1'b0);
        #3 RST_N = 1'b1;
        tick();
        tick();
        check_state("rst_after");
        issue(LD, 4'd9, 1'b0, 1'b0, 4'd0, 8'h00);
        check("rst_rf_cleared", bus.acc, 8'h00);

        // Randomized sequence against the reference model
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 1) do_ld(4'($urandom), 8'($urandom));
            issue(3'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 3)), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/acc_exec_ctrl.md
# acc_exec_ctrl

Accumulator-based execution controller that sits directly upstream of the ALU. It accepts one decoded instruction at a time over a valid/ready handshake and owns the accumulator, carry/zero flags and a small operand register file. It drives the ALU's CE, OP_CODE, operands and carry_in, then commits the ALU result back into the accumulator or register file.

## Interface
- SIZE, 8: datapath width; must match the ALU's SIZE.
- REG_AW, 4: register file address width, giving 2^REG_AW registers of SIZE bits.

Ports:
- CLK  in  1  sole clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction present.
- instr_ready  out  1  controller can accept an instruction.
- instr_op  in  3  operation, encoded as in OP_CODES.sv.
- instr_reg  in  REG_AW  register index: right operand, or destination for OP_ST.
- instr_use_carry  in  1  when 1, ALU carry_in = carry flag; when 0, carry_in = 0.
- ld_we  in  1  external register-file write strobe.
- ld_addr  in  REG_AW  external write address.
- ld_data  in  SIZE  external write data.
- alu_ce  out  1  to ALU CE.
- alu_op  out  3  to ALU OP_CODE.
- alu_left  out  SIZE  to ALU left_operand; always equals acc.
- alu_right  out  SIZE  to ALU right_operand; equals REG[latched index].
- alu_carry_in  out  1  to ALU carry_in.
- alu_carry_out  in  1  from ALU carry_out.
- alu_result  in  SIZE  from ALU op_out.
- acc  out  SIZE  accumulator.
- carry_flag  out  1  carry flag C.
- zero_flag  out  1  zero flag Z.
- result_valid  out  1  one-cycle pulse in the commit cycle.

## Operation
- FSM states: IDLE, EXEC, WB. WB is present only without the fast-path macro.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready, latch instr_op, instr_reg and instr_use_carry, then go to EXEC.
- EXEC:
  - alu_ce=1.
  - alu_op, alu_right and alu_carry_in come from the latched fields.
  - Default build: register alu_result and alu_carry_out, then go to WB.
- WB:
  - result_valid=1.
  - Commit per the rules below, then go to IDLE.
- Commit rules:
  - OP_ADD, OP_SUB: acc←result, C←carry_out, Z←(result==0).
  - OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LD: acc←result, Z←(result==0), C unchanged.
  - OP_ST: REG[idx]←result (which equals acc); acc, C and Z unchanged.
- Outside EXEC: alu_ce=0. alu_op, alu_right and alu_carry_in keep their last latched values.
- Register file:
  - ld_we writes REG[ld_addr]←ld_data in any state.
  - If an OP_ST commit targets the same address in the same cycle, the commit wins and the ld write is dropped.
  - Reads are registered-array reads, so a same-cycle ld write is not visible until the next cycle.
- Widths: all arithmetic is SIZE bits. Carry is the ALU's bit SIZE. There is no sign handling.
- All eight op codes are legal; there is no illegal-op path.

## Timing
- Reset (RST_N low, asynchronous):
  - State=IDLE; acc=0, C=0, Z=1; all registers=0.
  - Latched fields=0; instr_ready=1, alu_ce=0, result_valid=0.
- Reset mid-operation (EXEC or WB): the in-flight instruction is aborted with no commit, and all outputs take their reset values.
- Handshake:
  - Transfer occurs on the edge where instr_valid&instr_ready=1.
  - instr_ready is 0 from the cycle after acceptance until the FSM returns to IDLE.
- Default build, acceptance at edge N:
  - Cycle N+1: EXEC.
  - Cycle N+2: WB, result_valid=1, commit at end of cycle.
  - Cycle N+3: instr_ready=1.
  - Throughput: one instruction per 3 cycles.
- Instructions with use_carry see the C value committed by the previous instruction.

## Configuration
- ACC_EXEC_FAST_EN:
  - Defined: WB is removed. Commit happens at the end of EXEC, directly from the combinational alu_result and alu_carry_out. result_valid=1 in EXEC; latency is 2 cycles and instr_ready returns in N+2.
  - Undefined: the registered WB stage is used, as described above.

## Test plan
- ld r3←0x05, then OP_LD r3 → acc=0x05, Z=0, C=0; result_valid pulses exactly in cycle N+2 (N+1 with fast path).
- acc=0xFF, r1=0x01, OP_ADD r1, use_carry=0 → acc=0x00, C=1, Z=1.
- C=1, acc=0x10, r2=0x20, OP_ADD r2, use_carry=1 → alu_carry_in=1, acc=0x31, C=0, Z=0.
- acc=0x5A, OP_ST r7, with ld_we r7←0x11 in the commit cycle → r7=0x5A; acc=0x5A, and C and Z are unchanged.
- instr_valid held high for 3 back-to-back instructions → only one accepted per 3 cycles (2 with fast path); no instruction is lost or duplicated.
- RST_N pulsed low during EXEC of OP_ADD → no commit; acc=0, Z=1, C=0, instr_ready=1 immediately.
